// File: rtl/vg_drive_seq.sv
// VG93 drive sequencer: owns the TR-DOS #FF register, stretches the VG93 master reset,
// and walks the motor spin-up / head-settle / idle-timeout sequence that gates vg_hrdy.
module vg_drive_seq #(
  parameter int PRESC    = 28000,
  parameter int SPINUP_T = 500,
  parameter int SETTLE_T = 30,
  parameter int MOTOR_TO = 3000,
  parameter int RES_MIN  = 1400
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       wr_ff,
  input  logic [7:0] din,
  input  logic       vg_hld,
  output logic       vg_res_n,
  output logic [1:0] vg_a,
  output logic       vg_side,
  output logic       vg_hrdy,
  output logic       motor_on,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SPINUP,
    ST_RUN,
    ST_SETTLE,
    ST_READY
  } state_t;

  localparam logic [14:0] PRESC_LAST  = 15'(PRESC - 1);
  localparam logic [11:0] SPINUP_LAST = 12'(SPINUP_T - 1);
  localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_T - 1);
  localparam logic [11:0] MOTOR_LAST  = 12'(MOTOR_TO - 1);
  localparam logic [10:0] RES_LOAD    = 11'(RES_MIN);

  state_t      state;
  state_t      state_n;
  logic        hl_en;
  logic        req_res;
  logic [10:0] res_cnt;
  logic [14:0] presc;
  logic [11:0] tick_cnt;
  logic        tick;
  logic        tmr_clr;
  logic        drv_chg;
  logic        unused_din;

  assign unused_din = ^din[7:5];

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      vg_a    <= 2'd0;
      vg_side <= 1'b1;
      hl_en   <= 1'b0;
      req_res <= 1'b0;
    end else if (wr_ff) begin
      vg_a    <= din[1:0];
      vg_side <= ~din[4];
      hl_en   <= din[3];
      req_res <= din[2];
    end
  end

  // The counter only reloads while reset is requested, so a 0-then-1 pair yields RES_MIN+1 low cycles.
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      vg_res_n <= 1'b0;
      res_cnt  <= RES_LOAD;
    end else if (!req_res) begin
      vg_res_n <= 1'b0;
      res_cnt  <= RES_LOAD;
    end else if (!vg_res_n) begin
      if (res_cnt == 11'd0) begin
        vg_res_n <= 1'b1;
      end else begin
        res_cnt <= res_cnt - 11'd1;
      end
    end
  end

  assign tick = (presc == PRESC_LAST);

  // Tick counter saturates so long-lived states never wrap back into a terminal compare.
  always_ff @(posedge fclk) begin
    if (!rst_n || tmr_clr) begin
      presc    <= 15'd0;
      tick_cnt <= 12'd0;
    end else if (tick) begin
      presc <= 15'd0;
      if (tick_cnt != 12'hFFF) begin
        tick_cnt <= tick_cnt + 12'd1;
      end
    end else begin
      presc <= presc + 15'd1;
    end
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state <= ST_OFF;
    end else begin
      state <= state_n;
    end
  end

  assign drv_chg = wr_ff && (din[1:0] != vg_a);

  // A pending reset request pulls the FSM to OFF alongside the reset output itself.
  always_comb begin
    state_n = state;
    tmr_clr = 1'b0;
    if (!vg_res_n || !req_res) begin
      state_n = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          if (vg_hld) state_n = ST_SPINUP;
        end
        ST_SPINUP: begin
          if (tick && tick_cnt == SPINUP_LAST) state_n = ST_RUN;
        end
        ST_RUN: begin
          if (vg_hld) begin
            state_n = ST_SETTLE;
          end else if (wr_ff) begin
            tmr_clr = 1'b1;
          end else if (tick && tick_cnt == MOTOR_LAST) begin
            state_n = ST_OFF;
          end
        end
        ST_SETTLE: begin
          if (drv_chg) begin
            tmr_clr = 1'b1;
          end else if (!vg_hld) begin
            state_n = ST_RUN;
          end else if (tick && tick_cnt == SETTLE_LAST) begin
            state_n = ST_READY;
          end
        end
        ST_READY: begin
          if (drv_chg) begin
            state_n = ST_SETTLE;
          end else if (!vg_hld) begin
            state_n = ST_RUN;
          end
        end
        default: state_n = ST_OFF;
      endcase
    end
    if (state_n != state) tmr_clr = 1'b1;
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      vg_hrdy <= 1'b0;
    end else begin
      vg_hrdy <= (state == ST_READY) && hl_en;
    end
  end

  assign motor_on = (state != ST_OFF);
  assign busy     = (state == ST_SPINUP) || (state == ST_SETTLE);

endmodule

// File: tb/tb_vg_drive_seq.sv
// Directed bench for vg_drive_seq with shortened timing constants; each scenario
// task drives its own stimulus and checks hand-computed cycle positions.
module tb_vg_drive_seq;

  logic       fclk;
  logic       rst_n;
  logic       wr_ff;
  logic [7:0] din;
  logic       vg_hld;
  logic       vg_res_n;
  logic [1:0] vg_a;
  logic       vg_side;
  logic       vg_hrdy;
  logic       motor_on;
  logic       busy;

  int vectors;
  int miscompares;

  vg_drive_seq #(
    .PRESC(4), .SPINUP_T(3), .SETTLE_T(2), .MOTOR_TO(5), .RES_MIN(6)
  ) dut (
    .fclk(fclk), .rst_n(rst_n), .wr_ff(wr_ff), .din(din), .vg_hld(vg_hld),
    .vg_res_n(vg_res_n), .vg_a(vg_a), .vg_side(vg_side), .vg_hrdy(vg_hrdy),
    .motor_on(motor_on), .busy(busy)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    din   = d;
    wr_ff = 1'b1;
    step();
    wr_ff = 1'b0;
  endtask

  task automatic test_reset();
    logic exp;
    rst_n = 1'b0; wr_ff = 1'b0; din = 8'h00; vg_hld = 1'b0;
    repeat (3) step();
    vectors++; if (vg_res_n !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_res_n: got %b want 0", vg_res_n); end
    vectors++; if (vg_a !== 2'd0) begin miscompares++; $display("[TB] FAIL rst_vg_a: got %0d want 0", vg_a); end
    vectors++; if (vg_side !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_side: got %b want 1", vg_side); end
    vectors++; if (vg_hrdy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_hrdy: got %b want 0", vg_hrdy); end
    vectors++; if (motor_on !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_motor: got %b want 0", motor_on); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    step();
    step();
    wr(8'h04);
    vectors++; if (vg_a !== 2'd0) begin miscompares++; $display("[TB] FAIL wr04_vg_a: got %0d want 0", vg_a); end
    vectors++; if (vg_side !== 1'b1) begin miscompares++; $display("[TB] FAIL wr04_side: got %b want 1", vg_side); end
    vectors++; if (vg_res_n !== 1'b0) begin miscompares++; $display("[TB] FAIL res_stretch_p1: got %b want 0", vg_res_n); end
    for (int k = 2; k <= 8; k++) begin
      step();
      exp = (k >= 8);
      vectors++; if (vg_res_n !== exp) begin miscompares++; $display("[TB] FAIL res_stretch_p%0d: got %b want %b", k, vg_res_n, exp); end
    end
  endtask

  task automatic test_spinup_ready();
    logic exp_busy, exp_hrdy;
    wr(8'h0C);
    vg_hld = 1'b1;
    step();
    vectors++; if (motor_on !== 1'b1) begin miscompares++; $display("[TB] FAIL spin_motor: got %b want 1", motor_on); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL spin_busy: got %b want 1", busy); end
    for (int k = 2; k <= 23; k++) begin
      step();
      exp_busy = (k <= 12) || (k >= 14 && k <= 21);
      exp_hrdy = (k >= 23);
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL seq_busy_c%0d: got %b want %b", k, busy, exp_busy); end
      vectors++; if (vg_hrdy !== exp_hrdy) begin miscompares++; $display("[TB] FAIL seq_hrdy_c%0d: got %b want %b", k, vg_hrdy, exp_hrdy); end
    end
  endtask

  task automatic test_drive_change();
    logic exp_busy, exp_hrdy;
    wr(8'h0D);
    vectors++; if (vg_a !== 2'd1) begin miscompares++; $display("[TB] FAIL drv_vg_a: got %0d want 1", vg_a); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL drv_resettle: got %b want 1", busy); end
    for (int k = 2; k <= 10; k++) begin
      step();
      exp_busy = (k <= 8);
      exp_hrdy = (k >= 10);
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL drv_busy_c%0d: got %b want %b", k, busy, exp_busy); end
      vectors++; if (vg_hrdy !== exp_hrdy) begin miscompares++; $display("[TB] FAIL drv_hrdy_c%0d: got %b want %b", k, vg_hrdy, exp_hrdy); end
    end
  endtask

  task automatic test_motor_timeout();
    logic exp;
    vg_hld = 1'b0;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL run_busy: got %b want 0", busy); end
    for (int k = 2; k <= 21; k++) begin
      step();
      exp = (k <= 20);
      vectors++; if (vg_hrdy !== 1'b0) begin miscompares++; $display("[TB] FAIL run_hrdy_c%0d: got %b want 0", k, vg_hrdy); end
      vectors++; if (motor_on !== exp) begin miscompares++; $display("[TB] FAIL idle_motor_c%0d: got %b want %b", k, motor_on, exp); end
    end
    vg_hld = 1'b1;
    step();
    vg_hld = 1'b0;
    repeat (12) step();
    vectors++; if (busy !== 1'b0 || motor_on !== 1'b1) begin miscompares++; $display("[TB] FAIL run2_entry: got busy=%b motor=%b want busy=0 motor=1", busy, motor_on); end
    repeat (9) step();
    wr(8'h0D);
    for (int k = 11; k <= 30; k++) begin
      step();
      exp = (k <= 29);
      vectors++; if (motor_on !== exp) begin miscompares++; $display("[TB] FAIL extend_motor_c%0d: got %b want %b", k, motor_on, exp); end
    end
  endtask

  task automatic test_reset_write();
    logic exp;
    vg_hld = 1'b1;
    step();
    repeat (22) step();
    vectors++; if (vg_hrdy !== 1'b1) begin miscompares++; $display("[TB] FAIL rw_ready: got %b want 1", vg_hrdy); end
    vg_hld = 1'b0;
    wr(8'h08);
    wr(8'h0C);
    vectors++; if (vg_res_n !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_res_low: got %b want 0", vg_res_n); end
    vectors++; if (motor_on !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_motor_off: got %b want 0", motor_on); end
    vectors++; if (vg_hrdy !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_hrdy: got %b want 0", vg_hrdy); end
    vectors++; if (vg_a !== 2'd0) begin miscompares++; $display("[TB] FAIL rw_vg_a: got %0d want 0", vg_a); end
    for (int k = 3; k <= 9; k++) begin
      step();
      exp = (k >= 9);
      vectors++; if (vg_res_n !== exp) begin miscompares++; $display("[TB] FAIL rw_stretch_c%0d: got %b want %b", k, vg_res_n, exp); end
      vectors++; if (motor_on !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_hold_off_c%0d: got %b want 0", k, motor_on); end
    end
  endtask

  task automatic test_settle_race();
    vg_hld = 1'b1;
    step();
    repeat (20) step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL race_in_settle: got %b want 1", busy); end
    vg_hld = 1'b0;
    step();
    vectors++; if (busy !== 1'b0 || motor_on !== 1'b1) begin miscompares++; $display("[TB] FAIL race_run: got busy=%b motor=%b want busy=0 motor=1", busy, motor_on); end
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++; if (vg_hrdy !== 1'b0) begin miscompares++; $display("[TB] FAIL race_hrdy_c%0d: got %b want 0", k, vg_hrdy); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    $display("[TB] starting vg_drive_seq bench");
    test_reset();
    test_spinup_ready();
    test_drive_change();
    test_motor_timeout();
    test_reset_write();
    test_settle_race();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
